// File: rtl/lbp_histogram.sv
// lbp_histogram: snoops LBP codes into 2**CODE_W saturating bins, then streams them out on finish.
// Rev 1.0
`default_nettype none

module lbp_histogram #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [CODE_W-1:0] lbp_data,
  input  logic              finish,
  input  logic              hist_ready,
  output logic              hist_valid,
  output logic [CODE_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              extra_err
);

  localparam int              NBIN    = 2 ** CODE_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CODE_W-1:0] C_LAST  = '1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bins [NBIN];
  logic               r_hist_valid;
  logic [CODE_W-1:0]  r_hist_bin;
  logic [CNT_W-1:0]   r_hist_count;
  logic               r_hist_done;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic               r_extra_err;

  logic               w_accum;
  logic               w_xfer;
  logic [CODE_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]   w_bin0_nxt;

  assign w_accum   = (r_state == ST_ACCUM) && lbp_valid;
  assign w_idx_nxt = r_hist_bin + CODE_W'(1);
  // bin 0 is presented on the same edge that may still be counting into it
  assign w_bin0_nxt = (w_accum && (lbp_data == '0) && (r_bins[0] != C_CNT_MAX))
                      ? r_bins[0] + CNT_W'(1) : r_bins[0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    case (r_state)
      ST_ACCUM: if (finish) w_state_nxt = ST_DUMP;
      ST_DUMP: begin
        w_xfer = r_hist_valid && hist_ready;
        if (w_xfer && (r_hist_bin == C_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBIN; i++) r_bins[i] <= '0;
    end else if (w_accum) begin
      for (int i = 0; i < NBIN; i++) begin
        if ((lbp_data == CODE_W'(i)) && (r_bins[i] != C_CNT_MAX))
          r_bins[i] <= r_bins[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist_valid <= 1'b0;
      r_hist_bin   <= '0;
      r_hist_count <= '0;
      r_hist_done  <= 1'b0;
      r_sample_cnt <= '0;
      r_extra_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (lbp_valid && (r_sample_cnt != C_CNT_MAX))
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
          if (finish) begin
            r_hist_valid <= 1'b1;
            r_hist_bin   <= '0;
            r_hist_count <= w_bin0_nxt;
          end
        end
        ST_DUMP: begin
          if (lbp_valid) r_extra_err <= 1'b1;
          if (w_xfer) begin
            if (r_hist_bin == C_LAST) begin
              r_hist_valid <= 1'b0;
              r_hist_done  <= 1'b1;
            end else begin
              r_hist_bin   <= w_idx_nxt;
              r_hist_count <= r_bins[w_idx_nxt];
            end
          end
        end
        default: begin
          if (lbp_valid) r_extra_err <= 1'b1;
        end
      endcase
    end
  end

  assign hist_valid = r_hist_valid;
  assign hist_bin   = r_hist_bin;
  assign hist_count = r_hist_count;
  assign hist_done  = r_hist_done;
  assign sample_cnt = r_sample_cnt;
  assign extra_err  = r_extra_err;

endmodule

`default_nettype wire
